// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb bundle: requester side and uart_tx side.
// master = arbiter, slave = requesters plus uart_tx.
interface uart_tx_arb_if #(
  parameter int N = 2
);
  logic [N-1:0]   req_rdy;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_lock;
  logic [N-1:0]   req_fetch;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_rdy;
  logic           tx_fetch;
  logic           busy;

  modport master (
    input  req_rdy, req_data, req_lock, tx_fetch,
    output req_fetch, grant, tx_data, tx_rdy, busy
  );

  modport slave (
    output req_rdy, req_data, req_lock, tx_fetch,
    input  req_fetch, grant, tx_data, tx_rdy, busy
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N byte sources.
// Optional lock keeps messages contiguous; BURST bounds a locked grant.
module uart_tx_arb #(
  parameter int N     = 2,
  parameter int BURST = 0
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_arb_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT
  } state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [7:0]    cnt;
  logic [N-1:0]  grant_q;
  logic          busy_q;

  logic [IW-1:0] pick;
  logic          found;
  int            scan;
  logic          own_rdy;
  logic          own_lock;
  logic [7:0]    own_data;
  logic          burst_ok;

  // search starts just past the last owner, wrapping mod N
  always_comb begin
    pick  = '0;
    found = 1'b0;
    scan  = 0;
    for (int k = 1; k <= N; k++) begin
      scan = (int'(last) + k) % N;
      if (!found && bus.req_rdy[IW'(scan)]) begin
        found = 1'b1;
        pick  = IW'(scan);
      end
    end
  end

  always_comb begin
    own_rdy  = 1'b0;
    own_lock = 1'b0;
    own_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == IW'(i)) begin
        own_rdy  = bus.req_rdy[i];
        own_lock = bus.req_lock[i];
        own_data = bus.req_data[8*i +: 8];
      end
    end
  end

  assign burst_ok = (BURST == 0) ||
                    (int'(cnt) + 1 < BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      last    <= IW'(N - 1);
      cnt     <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            owner   <= pick;
            last    <= pick;
            cnt     <= '0;
            grant_q <= N'(1) << pick;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (own_rdy) begin
            state <= WAIT;
          end else if (!own_lock) begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.tx_fetch) begin
            cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            if (own_lock && burst_ok) begin
              state <= GRANT;
            end else begin
              state   <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // busy_q clears asynchronously, so tx_rdy drops with reset
  assign bus.tx_rdy    = busy_q & own_rdy;
  assign bus.tx_data   = own_data;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.req_fetch = bus.tx_fetch ? grant_q : '0;
endmodule
